// File: rtl/pulse_train_gen.sv
// pulse_train_gen: start-triggered train of n_pulses pulses of given width and period, selectable polarity
module pulse_train_gen #(
    parameter int CNT_W  = 16,
    parameter int WID_W  = 12,
    parameter int NUM_W  = 8,
    parameter bit RETRIG = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] period,
    input  logic [WID_W-1:0] width,
    input  logic [NUM_W-1:0] n_pulses,
    input  logic             invert,
    output logic             pulse,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t           state;
    logic             s1, s2, s3;
    logic             trig, load, zero_x, invert_q;
    logic [CNT_W-1:0] width_x, period_x, we_x, period_q, we_q, cnt;
    logic [NUM_W-1:0] n_q;
    assign trig     = s2 & ~s3;
    assign load     = trig && (state == IDLE || RETRIG);
    assign width_x  = CNT_W'(width);
    assign period_x = (period == '0) ? width_x : period;
    assign we_x     = (width_x < period_x) ? width_x : period_x;
    assign zero_x   = (n_pulses == '0) || (width == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, s2, s3} <= '0;
            state        <= IDLE;
            pulse        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pulse_cnt    <= '0;
            period_q     <= '0;
            we_q         <= '0;
            n_q          <= '0;
            invert_q     <= 1'b0;
            cnt          <= '0;
        end else begin
            s1   <= start;
            s2   <= s1;
            s3   <= s2;
            done <= 1'b0;
            if (load) begin
                period_q  <= period_x;
                we_q      <= we_x;
                n_q       <= n_pulses;
                invert_q  <= invert;
                cnt       <= CNT_W'(1);
                pulse_cnt <= zero_x ? '0 : NUM_W'(1);
                state     <= zero_x ? IDLE : HIGH;
                busy      <= !zero_x;
                done      <= zero_x;
                pulse     <= zero_x ? invert : ~invert;
            end else begin
                case (state)
                    HIGH: begin
                        if (cnt != we_q) begin
                            cnt <= cnt + 1'b1;
                        end else if (pulse_cnt == n_q) begin
                            state <= IDLE;
                            pulse <= invert_q;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (we_q == period_q) begin
                            // width fills the whole period: keep the level, start next pulse
                            cnt       <= CNT_W'(1);
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end else begin
                            state <= LOW;
                            pulse <= invert_q;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt == period_q) begin
                            state     <= HIGH;
                            pulse     <= ~invert_q;
                            cnt       <= CNT_W'(1);
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: pulse <= invert_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: scoreboard bench driving a RETRIG=0 and a RETRIG=1 instance from the same stimulus
module tb_pulse_train_gen;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, invert = 1'b0;
    logic [15:0] period = '0;
    logic [11:0] width = '0;
    logic [7:0]  n_pulses = '0;
    logic        pulse [2];
    logic        busy [2];
    logic        done [2];
    logic [7:0]  pcnt [2];
    typedef struct {int cnt; int act; int bsy; int cyc; bit inv;} item_t;
    item_t q0[$], q1[$];
    int total = 0, bad = 0, cyc = 0;
    int act [2], bsy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pulse_train_gen #(.RETRIG(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .period(period), .width(width),
        .n_pulses(n_pulses), .invert(invert), .pulse(pulse[0]), .busy(busy[0]),
        .done(done[0]), .pulse_cnt(pcnt[0]));
    pulse_train_gen #(.RETRIG(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .period(period), .width(width),
        .n_pulses(n_pulses), .invert(invert), .pulse(pulse[1]), .busy(busy[1]),
        .done(done[1]), .pulse_cnt(pcnt[1]));

    task automatic chk(input string nm, input int d, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d", nm, d, a, e);
        end
    endtask

    function automatic bit front_inv(input int d);
        if (d == 0) return (q0.size() > 0) ? q0[0].inv : 1'b0;
        return (q1.size() > 0) ? q1[0].inv : 1'b0;
    endfunction

    task automatic push(input int d, input int c, input int a, input int b, input int cy, input bit inv);
        item_t it;
        it.cnt = c; it.act = a; it.bsy = b; it.cyc = cy; it.inv = inv;
        if (d == 0) q0.push_back(it);
        else q1.push_back(it);
    endtask

    // monitor: accumulate per-train activity, compare against the scoreboard on every done
    always @(negedge clk) begin
        item_t it;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                act[d] = 0;
                bsy[d] = 0;
            end else begin
                if (busy[d]) begin
                    bsy[d]++;
                    if (pulse[d] != front_inv(d)) act[d]++;
                end
                if (done[d]) begin
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut%0d got=done want=none", d);
                    end else begin
                        if (d == 0) it = q0.pop_front();
                        else it = q1.pop_front();
                        chk("pulse_cnt", d, int'(pcnt[d]), it.cnt);
                        chk("active_cycles", d, act[d], it.act);
                        chk("busy_cycles", d, bsy[d], it.bsy);
                        chk("done_cycle", d, cyc, it.cyc);
                        chk("busy_at_done", d, int'(busy[d]), 0);
                    end
                    act[d] = 0;
                    bsy[d] = 0;
                end
            end
        end
    end

    task automatic train(input int p, input int w, input int n, input bit inv,
                         input int c, input int a, input int b, input int off);
        int t0;
        @(negedge clk);
        period = 16'(p); width = 12'(w); n_pulses = 8'(n); invert = inv;
        t0 = cyc;
        push(0, c, a, b, t0 + 3 + off, inv);
        push(1, c, a, b, t0 + 3 + off, inv);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL timeout got=pending%0d want=0", q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk({nm, "_pulse"}, d, int'(pulse[d]), 0);
            chk({nm, "_busy"}, d, int'(busy[d]), 0);
            chk({nm, "_done"}, d, int'(done[d]), 0);
            chk({nm, "_pulse_cnt"}, d, int'(pcnt[d]), 0);
        end
    endtask

    initial begin
        int t0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // 4 pulses of 3 high / 7 low, done E2+33
        train(10, 3, 4, 1'b0, 4, 12, 33, 33);
        wait_idle();
        // degenerate trains: immediate done, no pulse
        train(10, 3, 0, 1'b0, 0, 0, 0, 0);
        wait_idle();
        for (int d = 0; d < 2; d++) chk("n0_pulse_low", d, int'(pulse[d]), 0);
        train(10, 0, 3, 1'b0, 0, 0, 0, 0);
        wait_idle();
        for (int d = 0; d < 2; d++) chk("w0_pulse_low", d, int'(pulse[d]), 0);
        // width > period: merged 15-cycle high level
        train(5, 12, 3, 1'b0, 3, 15, 15, 15);
        wait_idle();
        // second start edge lands in pulse 2; only the RETRIG=1 instance restarts
        @(negedge clk);
        period = 16'd10; width = 12'd3; n_pulses = 8'd5; invert = 1'b0;
        t0 = cyc;
        push(0, 5, 15, 43, t0 + 46, 1'b0);
        push(1, 5, 19, 54, t0 + 57, 1'b0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 11) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        // inverted polarity: idles high
        train(4, 1, 2, 1'b1, 2, 2, 5, 5);
        wait_idle();
        for (int d = 0; d < 2; d++) chk("inv_idle_high", d, int'(pulse[d]), 1);
        // reset during LOW phase of pulse 2 aborts without done
        @(negedge clk);
        period = 16'd10; width = 12'd3; n_pulses = 8'd4; invert = 1'b0;
        t0 = cyc;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 18) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("pre_abort_busy", d, int'(busy[d]), 1);
        rst_n = 1'b0;
        #1 chk_idle("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        train(10, 3, 4, 1'b0, 4, 12, 33, 33);
        wait_idle();
        chk("scoreboard_empty", 0, q0.size() + q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
